// File: rtl/pwm_gen_pkg.sv
// Shared constants and types for the PWM generator.
// Build option: PWM_GEN_CENTER_ALIGN_EN selects center-aligned counting.
package pwm_gen_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_COUNT     = (1 << DEFAULT_WIDTH) - 1;
    localparam int PRESCALE_W    = 16;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } count_dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Tick strobe generator: one tick per PRESCALE enabled clocks.
// The phase only advances while enabled, so a pause resumes exactly where it stopped.
module pwm_prescaler
    import pwm_gen_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] RELOAD = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] phase_q;
    logic [PRESCALE_W-1:0] phase_d;

    // Down-counter with terminal count at zero; reload on each tick.
    always_comb begin
        phase_d = phase_q;
        if (enable) begin
            if (phase_q == '0) begin
                phase_d = RELOAD;
            end else begin
                phase_d = phase_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign tick = enable && (phase_q == '0);

endmodule

// File: rtl/pwm_generator.sv
// PWM generator with shadowed duty register loaded at period boundaries.
// Build option: PWM_GEN_CENTER_ALIGN_EN enables center-aligned (up/down) counting.
//
// Count direction (center-aligned build only):
//   state | meaning
//   UP    | counting 0 .. max, turn around at max
//   DOWN  | counting max-1 .. 1, period boundary at 1
module pwm_generator
    import pwm_gen_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_done
);

    localparam logic [WIDTH-1:0] CNT_MAX =
        (WIDTH == DEFAULT_WIDTH) ? WIDTH'(MAX_COUNT) : {WIDTH{1'b1}};

    logic             tick;
    logic             boundary;
    logic             accept;
    logic [WIDTH-1:0] cnt_q,         cnt_d;
    logic [WIDTH-1:0] duty_active_q, duty_active_d;
    logic [WIDTH-1:0] shadow_q,      shadow_d;
    logic             shadow_full_q, shadow_full_d;
    logic             pwm_q,         pwm_d;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

`ifdef PWM_GEN_CENTER_ALIGN_EN
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    count_dir_e dir_q, dir_d;

    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        boundary = 1'b0;
        if (tick) begin
            case (dir_q)
                UP: begin
                    if (cnt_q == CNT_MAX) begin
                        dir_d = DOWN;
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DOWN: begin
                    if (cnt_q == CNT_ONE) begin
                        dir_d    = UP;
                        cnt_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    dir_d = UP;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q <= UP;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    always_comb begin
        cnt_d    = cnt_q;
        boundary = 1'b0;
        if (tick) begin
            cnt_d    = cnt_q + 1'b1;
            boundary = (cnt_q == CNT_MAX);
        end
    end
`endif

    // Accept and load are mutually exclusive: accept needs an empty shadow,
    // load needs a full one, so a value taken at a boundary waits one period.
    always_comb begin
        accept        = duty_valid && !shadow_full_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        duty_active_d = duty_active_q;
        if (boundary && shadow_full_q) begin
            duty_active_d = shadow_q;
            shadow_full_d = 1'b0;
        end
        if (accept) begin
            shadow_d      = duty_in;
            shadow_full_d = 1'b1;
        end
        pwm_d = (cnt_d < duty_active_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            duty_active_q <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            pwm_q         <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            duty_active_q <= duty_active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            pwm_q         <= pwm_d;
        end
    end

    // Compare result is registered; enable only gates it so a pause takes
    // effect and releases in the same cycle.
    assign pwm_out     = pwm_q && enable;
    assign duty_ready  = !shadow_full_q;
    assign period_done = boundary;

endmodule

// File: tb/tb_pwm_generator.sv
// Directed self-checking bench for pwm_generator (PRESCALE=1 and PRESCALE=4 instances).
module tb_pwm_generator;
    import pwm_gen_pkg::*;

`ifdef PWM_GEN_CENTER_ALIGN_EN
    localparam int  PERIOD = 510;
    localparam bit  CENTER = 1'b1;
`else
    localparam int  PERIOD = 256;
    localparam bit  CENTER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en, valid, ready, pwm, pd;
    logic [7:0] duty;
    logic       en4, valid4, ready4, pwm4, pd4;
    logic [7:0] duty4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pwm_generator #(.WIDTH(8), .PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .enable(en), .duty_in(duty), .duty_valid(valid),
        .duty_ready(ready), .pwm_out(pwm), .period_done(pd)
    );

    pwm_generator #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .enable(en4), .duty_in(duty4), .duty_valid(valid4),
        .duty_ready(ready4), .pwm_out(pwm4), .period_done(pd4)
    );

    // Counter value at tick index i within a period.
    function automatic int model_cnt(input int i);
        if (CENTER && i >= 256) return 510 - i;
        return i;
    endfunction

    function automatic int exp_highs(input int d);
        int n = 0;
        for (int i = 0; i < PERIOD; i++) if (model_cnt(i) < d) n++;
        return n;
    endfunction

    task automatic wait_pd(input string name);
        int k = 0;
        @(negedge clk);
        while (!pd && k < 3 * PERIOD) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (pd !== 1'b1) begin
            fails++;
            $display("FAIL %s_wait_pd: period_done=%b expected 1 within bound", name, pd);
        end
    endtask

    task automatic wait_pd4(input string name);
        int k = 0;
        @(negedge clk);
        while (!pd4 && k < 12 * PERIOD) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (pd4 !== 1'b1) begin
            fails++;
            $display("FAIL %s_wait_pd4: period_done=%b expected 1 within bound", name, pd4);
        end
    endtask

    task automatic load(input logic [7:0] v);
        @(posedge clk);
        #1 valid = 1'b1; duty = v;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic load4(input logic [7:0] v);
        @(posedge clk);
        #1 valid4 = 1'b1; duty4 = v;
        @(posedge clk);
        #1 valid4 = 1'b0;
    endtask

    // Caller is at the negedge of a period_done cycle; observes one full period.
    task automatic measure(input string name, input int d);
        int highs = 0, shape = 0, pds = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (pwm) highs++;
            if (pwm !== (model_cnt(i) < d)) shape++;
            if (pd !== (i == PERIOD - 1)) pds++;
        end
        tests++;
        if (highs != exp_highs(d)) begin
            fails++;
            $display("FAIL %s_highs: got %0d expected %0d", name, highs, exp_highs(d));
        end
        tests++;
        if (shape != 0) begin
            fails++;
            $display("FAIL %s_shape: %0d cycles differ from expected waveform, expected 0", name, shape);
        end
        tests++;
        if (pds != 0) begin
            fails++;
            $display("FAIL %s_period_done: %0d misplaced cycles, expected 0", name, pds);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b1; en4 = 1'b1;
        valid = 1'b0; valid4 = 1'b0; duty = '0; duty4 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({pwm, pd, ready} !== 3'b001) begin
            fails++;
            $display("FAIL reset_outputs: pwm/pd/ready=%b expected 001", {pwm, pd, ready});
        end
        tests++;
        if ({pwm4, pd4, ready4} !== 3'b001) begin
            fails++;
            $display("FAIL reset_outputs4: pwm/pd/ready=%b expected 001", {pwm4, pd4, ready4});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        wait_pd("reset_idle");
        measure("reset_idle", 0);
    endtask

    task automatic test_half;
        load(8'd128);
        wait_pd("half");
        measure("half", 128);
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL half_ready: got %b expected 1", ready);
        end
    endtask

    task automatic test_extremes;
        load(8'd0);
        wait_pd("zero");
        measure("zero", 0);
        load(8'd255);
        wait_pd("full");
        measure("full", 255);
    endtask

    task automatic test_shadow;
        int highs = 0, rdy_bad = 0;
        load(8'd64);
        wait_pd("shadow");
        for (int i = 0; i < PERIOD; i++) begin
            @(posedge clk);
            #1 valid = (i == 10 || i == 12);
            duty = (i == 10) ? 8'd192 : 8'd10;
            @(negedge clk);
            if (pwm) highs++;
            if (ready !== (i < 11)) rdy_bad++;
        end
        tests++;
        if (highs != exp_highs(64)) begin
            fails++;
            $display("FAIL shadow_cur_highs: got %0d expected %0d", highs, exp_highs(64));
        end
        tests++;
        if (rdy_bad != 0) begin
            fails++;
            $display("FAIL shadow_ready: %0d cycles wrong, expected 0", rdy_bad);
        end
        measure("shadow_next", 192);
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL shadow_ready_back: got %b expected 1", ready);
        end
    endtask

    task automatic test_reset_mid;
        int highs = 0, first = -1;
        wait_pd("reset_mid");
        for (int i = 0; i <= 100; i++) begin
            @(posedge clk);
            #1 valid = (i == 5); duty = 8'd30;
            if (i == 100) reset = 1'b1;
        end
        @(negedge clk);
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_shadow_full: ready=%b expected 0", ready);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({pwm, pd, ready} !== 3'b001) begin
            fails++;
            $display("FAIL reset_mid_outputs: pwm/pd/ready=%b expected 001", {pwm, pd, ready});
        end
        for (int k = 1; k <= 2 * PERIOD; k++) begin
            @(negedge clk);
            if (pwm) highs++;
            if (pd && first < 0) first = k;
        end
        tests++;
        if (highs != 0) begin
            fails++;
            $display("FAIL reset_mid_highs: got %0d expected 0", highs);
        end
        tests++;
        if (first != PERIOD - 1) begin
            fails++;
            $display("FAIL reset_mid_first_pd: got %0d expected %0d", first, PERIOD - 1);
        end
    endtask

    task automatic test_prescale;
        int highs = 0, pds = 0, off_bad = 0, last = -1;
        load4(8'd2);
        wait_pd4("pre");
        for (int i = 0; i < 4 * PERIOD; i++) begin
            @(negedge clk);
            if (pwm4) highs++;
            if (pd4 !== (i == 4 * PERIOD - 1)) pds++;
        end
        tests++;
        if (highs != 4 * exp_highs(2)) begin
            fails++;
            $display("FAIL pre_highs: got %0d expected %0d", highs, 4 * exp_highs(2));
        end
        tests++;
        if (pds != 0) begin
            fails++;
            $display("FAIL pre_period_done: %0d misplaced cycles, expected 0", pds);
        end
        highs = 0;
        for (int i = 0; i < 4 * PERIOD + 200; i++) begin
            @(posedge clk);
            #1 en4 = !(i >= 4 && i < 54);
            @(negedge clk);
            if (pwm4) highs++;
            if (!en4 && (pwm4 || pd4)) off_bad++;
            if (pd4) begin
                last = i;
                break;
            end
        end
        #1 en4 = 1'b1;
        tests++;
        if (last != 4 * PERIOD + 49) begin
            fails++;
            $display("FAIL pre_stretch_len: pd at %0d expected %0d", last, 4 * PERIOD + 49);
        end
        tests++;
        if (highs != 4 * exp_highs(2)) begin
            fails++;
            $display("FAIL pre_stretch_highs: got %0d expected %0d", highs, 4 * exp_highs(2));
        end
        tests++;
        if (off_bad != 0) begin
            fails++;
            $display("FAIL pre_disabled_outputs: %0d active cycles while disabled, expected 0", off_bad);
        end
    endtask

`ifdef PWM_GEN_CENTER_ALIGN_EN
    task automatic test_center;
        load(8'd100);
        wait_pd("center");
        measure("center", 100);
        tests++;
        if (exp_highs(100) != 199) begin
            fails++;
            $display("FAIL center_model: got %0d expected 199", exp_highs(100));
        end
    endtask
`endif

    initial begin
        test_reset;
        test_half;
        test_extremes;
        test_shadow;
        test_reset_mid;
        test_prescale;
`ifdef PWM_GEN_CENTER_ALIGN_EN
        test_center;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 Parameter WIDTH, default 8, duty and counter width.
REQ-002 Parameter PRESCALE, default 1, clk cycles per counter tick (legal 1..65535).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  high = run; low = freeze counter and prescaler, force pwm_out low.
REQ-006 duty_in  input  WIDTH  requested high-time in ticks per period.
REQ-007 duty_valid  input  1  duty_in offered this cycle.
REQ-008 duty_ready  output  1  shadow register empty; transfer occurs when duty_valid and duty_ready are both high.
REQ-009 pwm_out  output  1  PWM waveform.
REQ-010 period_done  output  1  one-clk pulse on the last clk of each period (carry).

Function
REQ-011 Edge-aligned mode: counter cnt counts 0..2^WIDTH-1 on each tick, then wraps to 0; period = 2^WIDTH ticks.
REQ-012 pwm_out SHALL equal (cnt < duty_active) in the same cycle cnt holds that value, driven from a register (no glitches).
REQ-013 duty_active=0 -> pwm_out constantly low; duty_active=2^WIDTH-1 -> high for 2^WIDTH-1 of 2^WIDTH ticks.
REQ-014 Accepted duty_in is stored in a shadow register; duty_ready drops the cycle after acceptance.
REQ-015 On the tick where cnt wraps to 0, a full shadow moves to duty_active and duty_ready returns high in the next cycle; an empty shadow leaves duty_active unchanged.
REQ-016 A value accepted in the boundary cycle itself is not applied at that boundary; it is applied at the following boundary.
REQ-017 period_done SHALL be high for exactly one clk: the last clk of the final tick of the period; never while enable is low.
REQ-018 Tick = one clk every PRESCALE clks of enable high; PRESCALE=1 means every clk.
REQ-019 enable low: cnt, prescaler phase and duty_active hold; pwm_out=0; handshake still accepts into shadow.
REQ-020 enable reasserted: resume from held cnt and prescaler phase with no extra delay.
REQ-021 duty_valid while duty_ready is low is ignored; no stall or error flag.

Reset
REQ-022 On reset: cnt=0, prescaler=0, duty_active=0, shadow empty, duty_ready=1, pwm_out=0, period_done=0.
REQ-023 Reset mid-period aborts the period immediately; the pending shadow value is discarded.

Configuration
REQ-024 Macro PWM_GEN_CENTER_ALIGN_EN defined: center-aligned mode; cnt counts up 0..2^WIDTH-1, then down 2^WIDTH-2..1; period = 2^(WIDTH+1)-2 ticks.
REQ-025 Center mode: pwm_out=(cnt < duty_active); boundary/shadow load and period_done on the down-count tick at cnt=1; direction state resets to up.
REQ-026 Macro undefined: edge-aligned only; no direction state is synthesized.

Structure
REQ-027 Package pwm_gen_pkg holds default WIDTH, MAX_COUNT constant and the count-direction enum (UP, DOWN).
REQ-028 Sub-module pwm_prescaler (clk, reset, enable -> tick) generates the tick strobe.

Verification
REQ-029 WIDTH=8, PRESCALE=1, duty 128 loaded -> pwm_out 128 clk high, 128 low; period_done every 256 clk.
REQ-030 duty 0 -> pwm_out never high; duty 255 -> one low clk per 256; period_done unaffected.
REQ-031 duty 64 active, load 192 at cnt=10 -> duty_ready low until the wrap; next period 192 high; second load ignored while ready is low.
REQ-032 PRESCALE=4, duty 2 -> pwm_out high 8 clk per 1024-clk period; enable low 50 clk mid-period -> pwm_out 0, period stretched by exactly 50 clk.
REQ-033 reset at cnt=100 with shadow full -> next cycle all outputs at reset values, duty_ready=1, duty_active=0.
REQ-034 PWM_GEN_CENTER_ALIGN_EN, duty 100 -> pwm_out high 199 contiguous clk (100 up + 99 down) per 510-clk period; period_done at down-count cnt=1.
